// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: writeback source encodings and default widths.
// Used by the decoder, the MEM/WB register and the writeback/register-file stage.
package cpu_defs;

  localparam int XLEN_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU   = 2'b00,
    WB_SEL_PCIMM = 2'b01,
    WB_SEL_IMM   = 2'b10,
    WB_SEL_RSVD  = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/wb_src_mux.sv
// Writeback source select: load data wins, otherwise the 2-bit select picks
// ALU / PC+imm / imm; the reserved encoding yields zero.
module wb_src_mux
  import cpu_defs::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] mem_in,
  input  logic [XLEN-1:0] pc_imm_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [1:0]      sel_in,
  input  logic            mem_reg_in,
  output logic [XLEN-1:0] wb_data
);

  always_comb begin
    wb_data = '0;
    if (mem_reg_in) begin
      wb_data = mem_in;
    end else begin
      case (wb_sel_e'(sel_in))
        WB_SEL_ALU:   wb_data = alu_in;
        WB_SEL_PCIMM: wb_data = pc_imm_in;
        WB_SEL_IMM:   wb_data = imm_in;
        default:      wb_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file with two combinational read ports.
// Define WB_REGFILE_BYPASS_EN for write-first reads; otherwise reads return the old value.
module wb_regfile
  import cpu_defs::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  wb_alu_out_in,
  input  logic [XLEN-1:0]  wb_mem_data_in,
  input  logic [XLEN-1:0]  wb_pc_imm_in,
  input  logic [XLEN-1:0]  wb_imm_in,
  input  logic [AW-1:0]    wb_rd_in,
  input  logic [1:0]       wb_reg_in_sel_in,
  input  logic             wb_mem_reg_in,
  input  logic             wb_reg_wr_in,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             fwd_wr_en,
  output logic [AW-1:0]    fwd_wr_addr,
  output logic [XLEN-1:0]  fwd_wr_data,
  output logic [CNT_W-1:0] wr_count
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [XLEN-1:0]  wb_data;

  wb_src_mux #(
    .XLEN(XLEN)
  ) u_src_mux (
    .alu_in     (wb_alu_out_in),
    .mem_in     (wb_mem_data_in),
    .pc_imm_in  (wb_pc_imm_in),
    .imm_in     (wb_imm_in),
    .sel_in     (wb_reg_in_sel_in),
    .mem_reg_in (wb_mem_reg_in),
    .wb_data    (wb_data)
  );

  // x0 writes never commit, so regs_q[0] stays at its reset value of zero.
  assign fwd_wr_en   = wb_reg_wr_in && (wb_rd_in != '0);
  assign fwd_wr_addr = wb_rd_in;
  assign fwd_wr_data = wb_data;
  assign wr_count    = count_q;

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (fwd_wr_en) begin
      regs_d[wb_rd_in] = wb_data;
      count_d          = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rd_data [2];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;
  assign rs1_data   = rd_data[0];
  assign rs2_data   = rd_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef WB_REGFILE_BYPASS_EN
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                           (fwd_wr_en && (rd_addr[gi] == wb_rd_in)) ? wb_data :
                           regs_q[rd_addr[gi]];
`else
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 : regs_q[rd_addr[gi]];
`endif
    end
  endgenerate

endmodule
